decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 41 ++++
 rtl/decode_stage_if.sv | 14 +
 rtl/decode_stage_regfile.sv | 43 ++++
 rtl/decode_stage.sv | 164 ++++++++++++++++
 tb/tb_decode_stage.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// Shared encodings for the MIPS decode stage: opcodes, funct codes, ALU control
// values, the default bubble instruction and the decoded control bundle.
package decode_stage_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef struct packed {
    logic      regwrite;
    logic      memtoreg;
    logic      memwrite;
    logic      alusrc;
    logic      regdst;
    alu_ctrl_e alucontrol;
  } ctrl_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Register-file access bundle: two combinational read ports plus the
// writeback write port. master = decode side, slave = register file.
interface decode_stage_if;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  modport master (output ra1, ra2, we, waddr, wdata, input rd1, rd2);
  modport slave  (input ra1, ra2, we, waddr, wdata, output rd1, rd2);
endinterface

// File: rtl/decode_stage_regfile.sv
// 32x32 register file: r0 hard-wired to zero, write on rising edge, and a
// same-cycle write-through bypass so decode sees the value being written back.
module regfile
  import decode_stage_pkg::*;
(
  input logic            clk_i,
  input logic            reset_ni,
  decode_stage_if.slave  rf
);

  // Flattened storage; slice 0 is constant zero so r0 needs no special read path.
  logic [32*32-1:0] regs_flat;

  assign regs_flat[31:0] = '0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_reg
      logic [31:0] q_reg;

      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          q_reg <= '0;
        end else if (rf.we && (rf.waddr == 5'(gi))) begin
          q_reg <= rf.wdata;
        end
      end

      assign regs_flat[gi*32 +: 32] = q_reg;
    end
  endgenerate

  always_comb begin
    rf.rd1 = regs_flat[rf.ra1*32 +: 32];
    rf.rd2 = regs_flat[rf.ra2*32 +: 32];
    if (rf.we && (rf.waddr != 5'd0) && (rf.waddr == rf.ra1)) begin
      rf.rd1 = rf.wdata;
    end
    if (rf.we && (rf.waddr != 5'd0) && (rf.waddr == rf.ra2)) begin
      rf.rd2 = rf.wdata;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: IF/ID register with stall/flush, register file, early branch
// resolution and main/ALU decoder. Define DECODE_BR_FWD_EN for MEM->branch forwarding.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
)
(
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        stall_i,
  input  logic [31:0] instr_if32,
  input  logic [31:0] pc_plus4_if32,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_waddr_i5,
  input  logic [31:0] wb_wdata_i32,
`ifdef DECODE_BR_FWD_EN
  input  logic        fwd_a_i,
  input  logic        fwd_b_i,
  input  logic [31:0] mem_alu_i32,
`endif
  output logic        pc_beq_o,
  output logic        pc_j_o,
  output logic [31:0] pc_branch_o32,
  output logic [31:0] pc_plus4_o32,
  output logic [31:0] instr_o32,
  output logic [31:0] rd1_o32,
  output logic [31:0] rd2_o32,
  output logic [4:0]  rs_o5,
  output logic [4:0]  rt_o5,
  output logic [4:0]  rd_o5,
  output logic [31:0] signimm_o32,
  output logic        regwrite_o,
  output logic        memtoreg_o,
  output logic        memwrite_o,
  output logic        alusrc_o,
  output logic        regdst_o,
  output logic [2:0]  alucontrol_o3
);

  logic [31:0] instr_reg;
  logic [31:0] pc_plus4_reg;
  // Cleared by reset/flush so the bubble word never raises controls or
  // redirects, whatever NOP_INSTR happens to encode.
  logic        valid_reg;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] signimm;
  logic [31:0] br_a;
  logic [31:0] br_b;
  logic        br_eq;
  logic        flush;
  ctrl_t       ctrl;

  decode_stage_if rf_bus ();

  assign opcode  = instr_reg[31:26];
  assign funct   = instr_reg[5:0];
  assign signimm = sign_ext16(instr_reg[15:0]);

  assign rf_bus.ra1   = instr_reg[25:21];
  assign rf_bus.ra2   = instr_reg[20:16];
  assign rf_bus.we    = wb_we_i;
  assign rf_bus.waddr = wb_waddr_i5;
  assign rf_bus.wdata = wb_wdata_i32;

  regfile u_regfile (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .rf       (rf_bus)
  );

`ifdef DECODE_BR_FWD_EN
  assign br_a = fwd_a_i ? mem_alu_i32 : rf_bus.rd1;
  assign br_b = fwd_b_i ? mem_alu_i32 : rf_bus.rd2;
`else
  assign br_a = rf_bus.rd1;
  assign br_b = rf_bus.rd2;
`endif

  assign br_eq    = (br_a == br_b);
  assign pc_beq_o = valid_reg && (opcode == OP_BEQ) && br_eq;
  assign pc_j_o   = valid_reg && (opcode == OP_J);
  assign flush    = pc_beq_o | pc_j_o;

  // Stall wins over flush: a held branch re-resolves next cycle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      instr_reg    <= NOP_INSTR;
      pc_plus4_reg <= '0;
      valid_reg    <= 1'b0;
    end else if (!stall_i) begin
      if (flush) begin
        instr_reg    <= NOP_INSTR;
        pc_plus4_reg <= '0;
        valid_reg    <= 1'b0;
      end else begin
        instr_reg    <= instr_if32;
        pc_plus4_reg <= pc_plus4_if32;
        valid_reg    <= 1'b1;
      end
    end
  end

  always_comb begin
    ctrl = ctrl_t'('0);
    if (valid_reg) begin
      case (opcode)
        OP_RTYPE: begin
          ctrl.regwrite = 1'b1;
          ctrl.regdst   = 1'b1;
          case (funct)
            FN_ADD:  ctrl.alucontrol = ALU_ADD;
            FN_SUB:  ctrl.alucontrol = ALU_SUB;
            FN_AND:  ctrl.alucontrol = ALU_AND;
            FN_OR:   ctrl.alucontrol = ALU_OR;
            FN_SLT:  ctrl.alucontrol = ALU_SLT;
            default: ctrl.alucontrol = ALU_AND;
          endcase
        end
        OP_LW: begin
          ctrl.regwrite   = 1'b1;
          ctrl.memtoreg   = 1'b1;
          ctrl.alusrc     = 1'b1;
          ctrl.alucontrol = ALU_ADD;
        end
        OP_SW: begin
          ctrl.memwrite   = 1'b1;
          ctrl.alusrc     = 1'b1;
          ctrl.alucontrol = ALU_ADD;
        end
        OP_BEQ: begin
          ctrl.alucontrol = ALU_SUB;
        end
        OP_ADDI: begin
          ctrl.regwrite   = 1'b1;
          ctrl.alusrc     = 1'b1;
          ctrl.alucontrol = ALU_ADD;
        end
        default: begin
          ctrl = ctrl_t'('0);
        end
      endcase
    end
  end

  assign pc_branch_o32 = pc_plus4_reg + {signimm[29:0], 2'b00};
  assign pc_plus4_o32  = pc_plus4_reg;
  assign instr_o32     = instr_reg;
  assign rd1_o32       = rf_bus.rd1;
  assign rd2_o32       = rf_bus.rd2;
  assign rs_o5         = instr_reg[25:21];
  assign rt_o5         = instr_reg[20:16];
  assign rd_o5         = instr_reg[15:11];
  assign signimm_o32   = signimm;
  assign regwrite_o    = ctrl.regwrite;
  assign memtoreg_o    = ctrl.memtoreg;
  assign memwrite_o    = ctrl.memwrite;
  assign alusrc_o      = ctrl.alusrc;
  assign regdst_o      = ctrl.regdst;
  assign alucontrol_o3 = ctrl.alucontrol;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic against a behavioural model of the ID stage.
module tb_decode_stage;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] ADD_355  = 32'h00A5_1820;
  localparam logic [31:0] ADD_300  = 32'h0000_1820;
  localparam logic [31:0] BEQ_66   = 32'h10C6_FFFF;
  localparam logic [31:0] BEQ_12   = 32'h1022_0004;
  localparam logic [31:0] LW_I     = 32'h8C22_0004;
  localparam logic [31:0] ADDI_I   = 32'h2002_0005;
  localparam logic [31:0] J_I      = 32'h0800_0010;

  typedef struct packed {
    logic        beq;
    logic        j;
    logic [31:0] br;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  ctl;
    logic [2:0]  alu;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] instr_in;
  logic [31:0] pc4_in;
  logic        fwd_a;
  logic        fwd_b;
  logic [31:0] mem_alu;

  logic        pc_beq, pc_j, regwrite, memtoreg, memwrite, alusrc, regdst;
  logic [31:0] pc_branch, pc_plus4, instr_o, rd1, rd2, signimm;
  logic [4:0]  rs, rt, rd;
  logic [2:0]  alucontrol;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic [31:0] m_rf [32];

  decode_stage_if wb ();

  always #5 clk = ~clk;

  decode_stage dut (
    .clk_i         (clk),
    .reset_ni      (rst_n),
    .stall_i       (stall),
    .instr_if32    (instr_in),
    .pc_plus4_if32 (pc4_in),
    .wb_we_i       (wb.we),
    .wb_waddr_i5   (wb.waddr),
    .wb_wdata_i32  (wb.wdata),
`ifdef DECODE_BR_FWD_EN
    .fwd_a_i       (fwd_a),
    .fwd_b_i       (fwd_b),
    .mem_alu_i32   (mem_alu),
`endif
    .pc_beq_o      (pc_beq),
    .pc_j_o        (pc_j),
    .pc_branch_o32 (pc_branch),
    .pc_plus4_o32  (pc_plus4),
    .instr_o32     (instr_o),
    .rd1_o32       (rd1),
    .rd2_o32       (rd2),
    .rs_o5         (rs),
    .rt_o5         (rt),
    .rd_o5         (rd),
    .signimm_o32   (signimm),
    .regwrite_o    (regwrite),
    .memtoreg_o    (memtoreg),
    .memwrite_o    (memwrite),
    .alusrc_o      (alusrc),
    .regdst_o      (regdst),
    .alucontrol_o3 (alucontrol)
  );

  out_t obs;
  assign obs = {pc_beq, pc_j, pc_branch, pc_plus4, instr_o, rd1, rd2, signimm,
                rs, rt, rd, regwrite, memtoreg, memwrite, alusrc, regdst, alucontrol};

  task automatic model_reset();
    m_instr = NOP;
    m_pc4   = '0;
    m_valid = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
  endtask

  function automatic logic [31:0] rf_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb.we && wb.waddr == r) return wb.wdata;
    return m_rf[r];
  endfunction

  // Expected outputs from the architectural state: the instruction currently
  // in decode, the register contents, and this cycle's writeback/forwarding.
  function automatic out_t model();
    out_t        e = '0;
    logic [5:0]  op = m_instr[31:26];
    logic [5:0]  fn = m_instr[5:0];
    logic [31:0] a, b;
    e.instr = m_instr;
    e.pc4   = m_pc4;
    e.rs    = m_instr[25:21];
    e.rt    = m_instr[20:16];
    e.rd    = m_instr[15:11];
    e.rd1   = rf_read(e.rs);
    e.rd2   = rf_read(e.rt);
    e.imm   = 32'($signed(m_instr[15:0]));
    e.br    = m_pc4 + e.imm * 4;
    a = e.rd1;
    b = e.rd2;
`ifdef DECODE_BR_FWD_EN
    if (fwd_a) a = mem_alu;
    if (fwd_b) b = mem_alu;
`endif
    if (m_valid) begin
      e.beq = (op == 6'd4) && (a == b);
      e.j   = (op == 6'd2);
      case (op)
        6'd0: begin
          e.ctl = 5'b10001;
          case (fn)
            6'd32:   e.alu = 3'b010;
            6'd34:   e.alu = 3'b110;
            6'd36:   e.alu = 3'b000;
            6'd37:   e.alu = 3'b001;
            6'd42:   e.alu = 3'b111;
            default: e.alu = 3'b000;
          endcase
        end
        6'd35: begin e.ctl = 5'b11010; e.alu = 3'b010; end
        6'd43: begin e.ctl = 5'b00110; e.alu = 3'b010; end
        6'd4:  begin e.ctl = 5'b00000; e.alu = 3'b110; end
        6'd8:  begin e.ctl = 5'b10010; e.alu = 3'b010; end
        default: begin e.ctl = 5'b00000; e.alu = 3'b000; end
      endcase
    end
    return e;
  endfunction

  // One clock: inputs are stable, advance the model exactly as the stage should.
  task automatic tick();
    out_t e = model();
    @(posedge clk);
    if (rst_n) begin
      if (wb.we && wb.waddr != 5'd0) m_rf[wb.waddr] = wb.wdata;
      if (!stall) begin
        if (e.beq || e.j) begin
          m_instr = NOP; m_pc4 = '0; m_valid = 1'b0;
        end else begin
          m_instr = instr_in; m_pc4 = pc4_in; m_valid = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (obs !== out_t'('0)) begin n_bad++; $display("FAIL reset_outputs got %h exp 0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (obs !== out_t'('0)) begin n_bad++; $display("FAIL reset_release got %h exp 0", obs); end
    @(posedge clk); #1;
    instr_in = ADD_355; pc4_in = 32'h4;
    tick();
    #2;
    n_cmp++; if (rd1 !== 32'd0) begin n_bad++; $display("FAIL reset_r5 got %h exp 0", rd1); end
    n_cmp++; if (obs !== model()) begin n_bad++; $display("FAIL reset_first_decode got %h exp %h", obs, model()); end
    $display("test_reset done");
  endtask

  task automatic test_bypass();
    wb.we = 1'b1; wb.waddr = 5'd5; wb.wdata = 32'hDEAD_BEEF;
    #2;
    n_cmp++; if (rd1 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL bypass_rd1 got %h exp deadbeef", rd1); end
    n_cmp++; if (rd2 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL bypass_rd2 got %h exp deadbeef", rd2); end
    n_cmp++; if ({regwrite, memtoreg, memwrite, alusrc, regdst, alucontrol} !== 8'b10001_010 || rd !== 5'd3)
      begin n_bad++; $display("FAIL add_ctrl got %b/%0d exp 10001010/3", {regwrite, memtoreg, memwrite, alusrc, regdst, alucontrol}, rd); end
    tick();
    wb.we = 1'b0;
    #2;
    n_cmp++; if (rd1 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL stored_r5 got %h exp deadbeef", rd1); end
    $display("test_bypass done");
  endtask

  task automatic test_r0();
    instr_in = ADD_300;
    tick();
    wb.we = 1'b1; wb.waddr = 5'd0; wb.wdata = 32'h0000_1234;
    #2;
    n_cmp++; if (rd1 !== 32'd0) begin n_bad++; $display("FAIL r0_same_cycle got %h exp 0", rd1); end
    tick();
    wb.we = 1'b0;
    #2;
    n_cmp++; if (rd1 !== 32'd0 || rd2 !== 32'd0) begin n_bad++; $display("FAIL r0_after got %h/%h exp 0/0", rd1, rd2); end
    $display("test_r0 done");
  endtask

  task automatic test_branch_flush();
    instr_in = BEQ_66; pc4_in = 32'h0000_0010;
    tick();
    instr_in = LW_I; pc4_in = 32'h0000_0014;
    #2;
    n_cmp++; if (pc_beq !== 1'b1) begin n_bad++; $display("FAIL beq_taken got %b exp 1", pc_beq); end
    n_cmp++; if (pc_branch !== 32'h0000_000C) begin n_bad++; $display("FAIL beq_target got %h exp 0000000c", pc_branch); end
    n_cmp++; if (signimm !== 32'hFFFF_FFFF || alucontrol !== 3'b110 || regwrite !== 1'b0)
      begin n_bad++; $display("FAIL beq_decode got %h/%b/%b exp ffffffff/110/0", signimm, alucontrol, regwrite); end
    tick();
    #2;
    n_cmp++; if (instr_o !== NOP || pc_plus4 !== 32'd0 || pc_beq !== 1'b0)
      begin n_bad++; $display("FAIL beq_flush got %h/%h/%b exp %h/0/0", instr_o, pc_plus4, pc_beq, NOP); end
    $display("test_branch_flush done");
  endtask

  task automatic test_stall_flush();
    instr_in = BEQ_66; pc4_in = 32'h0000_0010;
    tick();
    instr_in = LW_I; pc4_in = 32'h0000_0014; stall = 1'b1;
    #2;
    n_cmp++; if (pc_beq !== 1'b1) begin n_bad++; $display("FAIL stall_beq got %b exp 1", pc_beq); end
    for (int k = 0; k < 2; k++) begin
      tick();
      #2;
      n_cmp++; if (instr_o !== BEQ_66 || pc_plus4 !== 32'h10)
        begin n_bad++; $display("FAIL stall_hold%0d got %h/%h exp %h/10", k, instr_o, pc_plus4, BEQ_66); end
    end
    stall = 1'b0;
    tick();
    #2;
    n_cmp++; if (instr_o !== NOP) begin n_bad++; $display("FAIL stall_then_flush got %h exp %h", instr_o, NOP); end
    tick();
    #2;
    n_cmp++; if (instr_o !== LW_I || {regwrite, memtoreg, memwrite, alusrc, regdst, alucontrol} !== 8'b11010_010)
      begin n_bad++; $display("FAIL lw_decode got %h/%b exp %h/11010010", instr_o, {regwrite, memtoreg, memwrite, alusrc, regdst, alucontrol}, LW_I); end
    $display("test_stall_flush done");
  endtask

  task automatic test_jump();
    instr_in = J_I; pc4_in = 32'h0000_0020;
    tick();
    instr_in = ADDI_I; pc4_in = 32'h0000_0024;
    #2;
    n_cmp++; if (pc_j !== 1'b1 || instr_o !== J_I || pc_plus4 !== 32'h20 || regwrite !== 1'b0)
      begin n_bad++; $display("FAIL jump got %b/%h/%h/%b exp 1/%h/20/0", pc_j, instr_o, pc_plus4, regwrite, J_I); end
    tick();
    #2;
    n_cmp++; if (pc_j !== 1'b0 || instr_o !== NOP) begin n_bad++; $display("FAIL jump_flush got %b/%h exp 0/%h", pc_j, instr_o, NOP); end
    tick();
    #2;
    n_cmp++; if ({regwrite, memtoreg, memwrite, alusrc, regdst, alucontrol} !== 8'b10010_010)
      begin n_bad++; $display("FAIL addi_decode got %b exp 10010010", {regwrite, memtoreg, memwrite, alusrc, regdst, alucontrol}); end
    $display("test_jump done");
  endtask

  task automatic test_fwd();
    logic exp_beq;
`ifdef DECODE_BR_FWD_EN
    exp_beq = 1'b1;
`else
    exp_beq = 1'b0;
`endif
    wb.we = 1'b1; wb.waddr = 5'd1; wb.wdata = 32'd1;
    tick();
    wb.waddr = 5'd2; wb.wdata = 32'd2;
    tick();
    wb.we = 1'b0;
    instr_in = BEQ_12; pc4_in = 32'h0000_0040;
    tick();
    instr_in = ADDI_I;
    fwd_b = 1'b1; mem_alu = 32'd1;
    #2;
    n_cmp++; if (pc_beq !== exp_beq) begin n_bad++; $display("FAIL fwd_beq got %b exp %b", pc_beq, exp_beq); end
    n_cmp++; if (pc_branch !== 32'h0000_0050) begin n_bad++; $display("FAIL fwd_target got %h exp 00000050", pc_branch); end
    fwd_b = 1'b0;
    #1;
    n_cmp++; if (pc_beq !== 1'b0) begin n_bad++; $display("FAIL raw_beq got %b exp 0", pc_beq); end
    tick();
    $display("test_fwd done");
  endtask

  task automatic test_random();
    logic [5:0] ops [7] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2, 6'd0};
    logic [5:0] fns [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
    logic [5:0] op, fn;
    out_t       e;
    for (int i = 0; i < 300; i++) begin
      op = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      fn = fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 5) == 0) fn = 6'($urandom);
      instr_in = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), fn};
      pc4_in   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      stall    = ($urandom_range(0, 3) == 0);
      wb.we    = $urandom_range(0, 1) == 1;
      wb.waddr = 5'($urandom_range(0, 3));
      wb.wdata = $urandom_range(0, 1) == 1 ? 32'($urandom_range(0, 2)) : $urandom;
      fwd_a    = $urandom_range(0, 3) == 0;
      fwd_b    = $urandom_range(0, 3) == 0;
      mem_alu  = 32'($urandom_range(0, 2));
      #2;
      e = model();
      n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL rand[%0d] got %h exp %h", i, obs, e); end
      tick();
    end
    stall = 1'b0; wb.we = 1'b0; fwd_a = 1'b0; fwd_b = 1'b0;
    $display("test_random done");
  endtask

  task automatic test_reset_override();
    wb.we = 1'b0;
    instr_in = BEQ_66; pc4_in = 32'h10;
    tick();
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (obs !== out_t'('0)) begin n_bad++; $display("FAIL reset_mid_stall got %h exp 0", obs); end
    tick();
    #2;
    n_cmp++; if (obs !== out_t'('0)) begin n_bad++; $display("FAIL reset_held got %h exp 0", obs); end
    stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #2;
    n_cmp++; if (pc_beq !== 1'b1) begin n_bad++; $display("FAIL pre_flush_beq got %b exp 1", pc_beq); end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (obs !== out_t'('0)) begin n_bad++; $display("FAIL reset_mid_flush got %h exp 0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    instr_in = ADD_355;
    tick();
    #2;
    n_cmp++; if (rd1 !== 32'd0 || instr_o !== ADD_355)
      begin n_bad++; $display("FAIL regs_cleared got %h/%h exp 0/%h", rd1, instr_o, ADD_355); end
    $display("test_reset_override done");
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; instr_in = '0; pc4_in = '0;
    wb.we = 1'b0; wb.waddr = '0; wb.wdata = '0; wb.ra1 = '0; wb.ra2 = '0;
    fwd_a = 1'b0; fwd_b = 1'b0; mem_alu = '0;
    model_reset();
    test_reset();
    test_bypass();
    test_r0();
    test_branch_flush();
    test_stall_flush();
    test_jump();
    test_fwd();
    test_random();
    test_reset_override();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
